// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle between the EX stage and the multiply/divide unit
interface mult_div_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;
  logic             HiWrite;
  logic             LoWrite;
  modport master(output Start, Op, A, B, input Busy, Done, HiOut, LoOut, HiWrite, LoWrite);
  modport slave(input Start, Op, A, B, output Busy, Done, HiOut, LoOut, HiWrite, LoWrite);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiply / restoring divide plus MTHI/MTLO, feeding HI/LO
module mult_div_unit #(parameter int WIDTH = 32) (
  input logic       Clk,
  input logic       Reset,
  mult_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] opnd, hi, lo, hi_out, lo_out;
  logic [CW-1:0] count;
  logic is_div, neg_a, neg_b, dz, busy, done, hw, lw;
  logic signed_op;
  logic [WIDTH-1:0] abs_a, abs_b, q_fix, rem_src, r_fix;
  logic [WIDTH:0] mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] p_fix;
  assign signed_op = ~bus.Op[0];
  assign abs_a = (signed_op && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign abs_b = (signed_op && bus.B[WIDTH-1]) ? -bus.B : bus.B;
  assign mul_sum = lo[0] ? {1'b0, hi} + {1'b0, opnd} : {1'b0, hi};
  assign div_sh = {hi, lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd};
  assign p_fix = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
  // a zero divisor leaves the dividend parked in lo so HI can return it unchanged
  assign q_fix = dz ? '1 : (neg_a ^ neg_b) ? -lo : lo;
  assign rem_src = dz ? lo : hi;
  assign r_fix = neg_a ? -rem_src : rem_src;
  assign bus.Busy = busy;
  assign bus.Done = done;
  assign bus.HiOut = hi_out;
  assign bus.LoOut = lo_out;
  assign bus.HiWrite = hw;
  assign bus.LoWrite = lw;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      hw <= 1'b0;
      lw <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start && !bus.Op[2]) begin
            is_div <= bus.Op[1];
            neg_a <= signed_op & bus.A[WIDTH-1];
            neg_b <= signed_op & bus.B[WIDTH-1];
            dz <= bus.Op[1] && bus.B == '0;
            opnd <= bus.Op[1] ? abs_b : abs_a;
            lo <= bus.Op[1] ? abs_a : abs_b;
            hi <= '0;
            count <= '0;
            busy <= 1'b1;
            state <= CALC;
          end else if (bus.Start && !bus.Op[1]) begin
            done <= 1'b1;
            hw <= ~bus.Op[0];
            lw <= bus.Op[0];
            if (bus.Op[0]) lo_out <= bus.A;
            else hi_out <= bus.A;
            state <= DONE;
          end
        end
        CALC: begin
          if (!is_div) {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
          else if (!dz) begin
            hi <= div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], ~div_diff[WIDTH]};
          end
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          {hi_out, lo_out} <= is_div ? {r_fix, q_fix} : p_fix;
          busy <= 1'b0;
          done <= 1'b1;
          hw <= 1'b1;
          lw <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          hw <= 1'b0;
          lw <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench; expected HI/LO/strobes/latency queued at issue, popped on Done
module tb_mult_div_unit;
  localparam int W = 32;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  mult_div_if #(.WIDTH(W)) bus();
  mult_div_unit #(.WIDTH(W)) dut(.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic hw;
    logic lw;
    int start;
    int lat;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] hi_arch = '0;
  logic [W-1:0] lo_arch = '0;
  always @(posedge Clk) cyc <= cyc + 1;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    int ia, ib;
    ia = a;
    ib = b;
    case (op)
      3'd0: return longint'($signed(a)) * longint'($signed(b));
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(ia % ib), 32'(ia / ib)};
      end
      3'd3: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: return 64'h0;
    endcase
  endfunction
  task automatic issue(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, bit expect_it);
    exp_t e;
    logic [63:0] r;
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op = op;
    bus.A = a;
    bus.B = b;
    if (expect_it) begin
      if (op == 3'd4) begin
        hi_arch = a;
        e.hw = 1'b1;
        e.lw = 1'b0;
      end else if (op == 3'd5) begin
        lo_arch = a;
        e.hw = 1'b0;
        e.lw = 1'b1;
      end else begin
        r = model(op, a, b);
        hi_arch = r[63:32];
        lo_arch = r[31:0];
        e.hw = 1'b1;
        e.lw = 1'b1;
      end
      e.hi = hi_arch;
      e.lo = lo_arch;
      e.start = cyc + 1;
      e.lat = op[2] ? 1 : 34;
      sb.push_back(e);
    end
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.Op = 3'($urandom);
    bus.A = $urandom;
    bus.B = $urandom;
    if (expect_it) check("busy_after_start", 64'(bus.Busy), op[2] ? 64'd0 : 64'd1);
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge Clk);
    #1;
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask
  always @(negedge Clk) begin
    if (bus.HiWrite || bus.LoWrite) check("strobe_without_done", 64'(bus.Done), 64'd1);
    if (bus.Done) begin
      if (sb.size() == 0) check("extra_done", 64'd1, 64'd0);
      else begin
        me = sb.pop_front();
        check("hi_out", 64'(bus.HiOut), 64'(me.hi));
        check("lo_out", 64'(bus.LoOut), 64'(me.lo));
        check("hi_write", 64'(bus.HiWrite), 64'(me.hw));
        check("lo_write", 64'(bus.LoWrite), 64'(me.lw));
        check("latency", 64'(cyc - me.start + 1), 64'(me.lat));
        check("busy_at_done", 64'(bus.Busy), 64'd0);
      end
    end
  end
  initial begin
    bus.Start = 1'b0;
    bus.Op = 3'd0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(negedge Clk);
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    check("rst_strobes", 64'({bus.HiWrite, bus.LoWrite}), 64'd0);
    check("rst_hi_lo", {bus.HiOut, bus.LoOut}, 64'd0);
    Reset = 1'b0;
    issue(3'd0, 32'd7, 32'd6, 1); drain();
    issue(3'd0, -32'sd3, 32'd5, 1); drain();
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); drain();
    issue(3'd2, -32'sd7, 32'd2, 1); drain();
    issue(3'd3, 32'd100, 32'd0, 1); drain();
    issue(3'd2, -32'sd7, 32'd0, 1); drain();
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1); drain();
    issue(3'd5, 32'h1234, 32'd0, 1); drain();
    issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1); drain();
    issue(3'd0, 32'h8000_0000, 32'h8000_0000, 1); drain();
    for (int i = 0; i < 10; i++) begin
      issue(3'($urandom_range(0, 5)), $urandom, (i % 4 == 3) ? 32'd0 : $urandom, 1);
      drain();
    end
    issue(3'd6, 32'h55, 32'h66, 0);
    check("op11x_busy", 64'(bus.Busy), 64'd0);
    repeat (5) @(negedge Clk);
    issue(3'd0, 32'd1000, -32'sd3, 1);
    repeat (5) @(negedge Clk);
    issue(3'd1, 32'd123, 32'd456, 0);
    drain();
    repeat (40) @(negedge Clk);
    check("hold_hi", 64'(bus.HiOut), 64'(hi_arch));
    check("hold_lo", 64'(bus.LoOut), 64'(lo_arch));
    issue(3'd2, 32'd1000, 32'd7, 0);
    repeat (8) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    hi_arch = '0;
    lo_arch = '0;
    check("abort_busy", 64'(bus.Busy), 64'd0);
    check("abort_done", 64'(bus.Done), 64'd0);
    check("abort_strobes", 64'({bus.HiWrite, bus.LoWrite}), 64'd0);
    check("abort_hi_lo", {bus.HiOut, bus.LoOut}, 64'd0);
    repeat (40) @(negedge Clk);
    issue(3'd0, 32'd7, 32'd6, 1); drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
